// File: rtl/ram_lvt_nrnw.sv
// Multi-port RAM: nRPORTS read / nWPORTS write ports on one clock. Each write port
// owns a bank replicated once per read port, and a byte-lane LVT selects the live bank.
module ram_lvt_nrnw #(
    parameter int NUM_WMASKS = 4,
    parameter int MEMD       = 512,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int nRPORTS    = 2,
    parameter int nWPORTS    = 2,
    parameter int IZERO      = 0,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic [nWPORTS-1:0]               wcsb,
    input  logic [nWPORTS*NUM_WMASKS-1:0]    wmask,
    input  logic [nWPORTS*ADDR_WIDTH-1:0]    waddr,
    input  logic [nWPORTS*DATA_WIDTH-1:0]    wdin,
    input  logic [nRPORTS-1:0]               rcsb,
    input  logic [nRPORTS*ADDR_WIDTH-1:0]    raddr,
    output logic [nRPORTS*DATA_WIDTH-1:0]    dout,
    output logic [nRPORTS-1:0]               rvalid,
    output logic                             wconflict
);
    localparam int LANE_W = DATA_WIDTH / NUM_WMASKS;
    localparam int LVT_W  = (nWPORTS > 1) ? $clog2(nWPORTS) : 1;
    localparam logic [ADDR_WIDTH:0] MEMD_W = (ADDR_WIDTH + 1)'(MEMD);

    logic [ADDR_WIDTH-1:0] w_waddr [nWPORTS];
    logic [NUM_WMASKS-1:0] w_wmask [nWPORTS];
    logic [DATA_WIDTH-1:0] w_wdata [nWPORTS];
    logic [nWPORTS-1:0]    w_wen;
    logic [ADDR_WIDTH-1:0] w_raddr [nRPORTS];
    logic [nRPORTS-1:0]    w_rin;
    logic [nRPORTS-1:0]    w_ren;
    logic [DATA_WIDTH-1:0] w_bank_q [nWPORTS][nRPORTS];
    logic [NUM_WMASKS-1:0] w_hit [nRPORTS];
    logic [DATA_WIDTH-1:0] w_bdata [nRPORTS];
    logic                  w_conf;

    logic [NUM_WMASKS-1:0][LVT_W-1:0] r_lvt [MEMD];
    logic [NUM_WMASKS-1:0][LVT_W-1:0] r_sel [nRPORTS];
    logic [NUM_WMASKS-1:0]            r_hit [nRPORTS];
    logic [DATA_WIDTH-1:0]            r_bdata [nRPORTS];
    logic [nRPORTS-1:0]               r_rvalid;
    logic [nRPORTS-1:0]               r_pass;
    logic                             r_wconflict;

    genvar gi, gj;

    generate
        for (gi = 0; gi < nWPORTS; gi++) begin : g_wunpack
            assign w_waddr[gi] = waddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wmask[gi] = wmask[gi*NUM_WMASKS +: NUM_WMASKS];
            assign w_wdata[gi] = wdin[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_wen[gi]   = rst_l && !wcsb[gi] && ({1'b0, w_waddr[gi]} < MEMD_W);
        end

        for (gi = 0; gi < nRPORTS; gi++) begin : g_runpack
            assign w_raddr[gi] = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_rin[gi]   = ({1'b0, w_raddr[gi]} < MEMD_W);
            assign w_ren[gi]   = rst_l && !rcsb[gi] && w_rin[gi];
        end

        // Bank gi, replica gj: written only by write port gi, read only by read port gj.
        for (gi = 0; gi < nWPORTS; gi++) begin : g_bank_w
            for (gj = 0; gj < nRPORTS; gj++) begin : g_bank_r
                if (IZERO != 0) begin : g_mem
                    logic [DATA_WIDTH-1:0] r_mem [MEMD] = '{default: '0};
                    logic [DATA_WIDTH-1:0] r_q;
                    always_ff @(posedge clk) begin
                        if (w_wen[gi]) begin
                            for (int l = 0; l < NUM_WMASKS; l++) begin
                                if (w_wmask[gi][l])
                                    r_mem[w_waddr[gi]][l*LANE_W +: LANE_W] <= w_wdata[gi][l*LANE_W +: LANE_W];
                            end
                        end
                        if (w_ren[gj])
                            r_q <= r_mem[w_raddr[gj]];
                    end
                    assign w_bank_q[gi][gj] = r_q;
                end else begin : g_mem
                    logic [DATA_WIDTH-1:0] r_mem [MEMD];
                    logic [DATA_WIDTH-1:0] r_q;
                    always_ff @(posedge clk) begin
                        if (w_wen[gi]) begin
                            for (int l = 0; l < NUM_WMASKS; l++) begin
                                if (w_wmask[gi][l])
                                    r_mem[w_waddr[gi]][l*LANE_W +: LANE_W] <= w_wdata[gi][l*LANE_W +: LANE_W];
                            end
                        end
                        if (w_ren[gj])
                            r_q <= r_mem[w_raddr[gj]];
                    end
                    assign w_bank_q[gi][gj] = r_q;
                end
            end
        end
    endgenerate

    // Ascending port order: the last assignment (highest port) owns a contested lane.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int a = 0; a < MEMD; a++)
                r_lvt[a] <= '0;
        end else begin
            for (int w = 0; w < nWPORTS; w++) begin
                if (w_wen[w]) begin
                    for (int l = 0; l < NUM_WMASKS; l++) begin
                        if (w_wmask[w][l])
                            r_lvt[w_waddr[w]][l] <= LVT_W'(w);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < nRPORTS; r++) begin
            w_hit[r]   = '0;
            w_bdata[r] = '0;
            for (int w = 0; w < nWPORTS; w++) begin
                for (int l = 0; l < NUM_WMASKS; l++) begin
                    if ((BYPASS != 0) && w_wen[w] && w_wmask[w][l] && (w_waddr[w] == w_raddr[r])) begin
                        w_hit[r][l] = 1'b1;
                        w_bdata[r][l*LANE_W +: LANE_W] = w_wdata[w][l*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    always_comb begin
        w_conf = 1'b0;
        for (int i = 0; i < nWPORTS; i++) begin
            for (int j = i + 1; j < nWPORTS; j++) begin
                if (w_wen[i] && w_wen[j] && (w_waddr[i] == w_waddr[j]) && |(w_wmask[i] & w_wmask[j]))
                    w_conf = 1'b1;
            end
        end
    end

    // Read-side selectors only load on an enabled read, which makes dout hold when idle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rvalid    <= '0;
            r_pass      <= '0;
            r_wconflict <= 1'b0;
            for (int r = 0; r < nRPORTS; r++) begin
                r_sel[r]   <= '0;
                r_hit[r]   <= '0;
                r_bdata[r] <= '0;
            end
        end else begin
            r_wconflict <= w_conf;
            for (int r = 0; r < nRPORTS; r++) begin
                r_rvalid[r] <= !rcsb[r];
                if (!rcsb[r]) begin
                    r_pass[r]  <= w_rin[r];
                    r_sel[r]   <= r_lvt[w_raddr[r]];
                    r_hit[r]   <= w_hit[r];
                    r_bdata[r] <= w_bdata[r];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < nRPORTS; gi++) begin : g_rout
            for (gj = 0; gj < NUM_WMASKS; gj++) begin : g_lane
                logic [LANE_W-1:0] w_lane;
                always_comb begin
                    w_lane = w_bank_q[r_sel[gi][gj]][gi][gj*LANE_W +: LANE_W];
                    if (r_hit[gi][gj])
                        w_lane = r_bdata[gi][gj*LANE_W +: LANE_W];
                    if (!r_pass[gi])
                        w_lane = '0;
                end
                assign dout[gi*DATA_WIDTH + gj*LANE_W +: LANE_W] = w_lane;
            end
        end
    endgenerate

    assign rvalid    = r_rvalid;
    assign wconflict = r_wconflict;

endmodule

// File: tb/tb_ram_lvt_nrnw.sv
// Directed bench for ram_lvt_nrnw: three instances share stimulus
// (A: bypass on, B: bypass off, C: MEMD=500).
module tb_ram_lvt_nrnw;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int NM = 4;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst_l = 1'b1;
    logic [NW-1:0]    wcsb = '1;
    logic [NW*NM-1:0] wmask = '0;
    logic [NW*AW-1:0] waddr = '0;
    logic [NW*DW-1:0] wdin = '0;
    logic [NR-1:0]    rcsb = '1;
    logic [NR*AW-1:0] raddr = '0;

    logic [NR*DW-1:0] dout_a, dout_b, dout_c;
    logic [NR-1:0]    rvalid_a, rvalid_b, rvalid_c;
    logic             wconf_a, wconf_b, wconf_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_lvt_nrnw #(.MEMD(512), .IZERO(1), .BYPASS(1)) u_a (
        .clk(clk), .rst_l(rst_l), .wcsb(wcsb), .wmask(wmask), .waddr(waddr), .wdin(wdin),
        .rcsb(rcsb), .raddr(raddr), .dout(dout_a), .rvalid(rvalid_a), .wconflict(wconf_a));

    ram_lvt_nrnw #(.MEMD(512), .IZERO(1), .BYPASS(0)) u_b (
        .clk(clk), .rst_l(rst_l), .wcsb(wcsb), .wmask(wmask), .waddr(waddr), .wdin(wdin),
        .rcsb(rcsb), .raddr(raddr), .dout(dout_b), .rvalid(rvalid_b), .wconflict(wconf_b));

    ram_lvt_nrnw #(.MEMD(500), .IZERO(1), .BYPASS(1)) u_c (
        .clk(clk), .rst_l(rst_l), .wcsb(wcsb), .wmask(wmask), .waddr(waddr), .wdin(wdin),
        .rcsb(rcsb), .raddr(raddr), .dout(dout_c), .rvalid(rvalid_c), .wconflict(wconf_c));

    task automatic idle();
        wcsb  = '1;
        wmask = '0;
        rcsb  = '1;
    endtask

    task automatic set_w(input int p, input logic [AW-1:0] a, input logic [NM-1:0] m, input logic [DW-1:0] d);
        wcsb[p]            = 1'b0;
        waddr[p*AW +: AW]  = a;
        wmask[p*NM +: NM]  = m;
        wdin[p*DW +: DW]   = d;
    endtask

    task automatic set_r(input int p, input logic [AW-1:0] a);
        rcsb[p]           = 1'b0;
        raddr[p*AW +: AW] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        set_w(0, 9'd5, 4'hF, 32'hFFFF_FFFF);
        set_r(0, 9'd5);
        #2 rst_l = 1'b0;
        repeat (3) step();
        n_vec++; if (dout_a !== '0)      begin n_err++; $display("FAIL reset_dout: got %h want 0", dout_a); end
        n_vec++; if (rvalid_a !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", rvalid_a); end
        n_vec++; if (wconf_a !== 1'b0)   begin n_err++; $display("FAIL reset_wconflict: got %b want 0", wconf_a); end
        idle();
        rst_l = 1'b1;
        $display("test_reset: outputs cleared while rst_l low");
    endtask

    task automatic test_first_read();
        set_r(0, 9'd5);
        set_r(1, 9'd300);
        step();
        n_vec++; if (dout_a[31:0] !== 32'h0)  begin n_err++; $display("FAIL first_read_p0: got %h want 00000000", dout_a[31:0]); end
        n_vec++; if (dout_a[63:32] !== 32'h0) begin n_err++; $display("FAIL first_read_p1: got %h want 00000000", dout_a[63:32]); end
        n_vec++; if (rvalid_a !== 2'b11)      begin n_err++; $display("FAIL first_read_rvalid: got %b want 11", rvalid_a); end
        idle();
        step();
        n_vec++; if (rvalid_a !== 2'b00)      begin n_err++; $display("FAIL idle_rvalid: got %b want 00", rvalid_a); end
        $display("test_first_read: @5/@300 read zero, idle drops rvalid");
    endtask

    task automatic test_overwrite();
        set_w(0, 9'd10, 4'hF, 32'hAABB_CCDD);
        step();
        idle();
        set_w(1, 9'd10, 4'h1, 32'h0000_0011);
        step();
        n_vec++; if (wconf_a !== 1'b0) begin n_err++; $display("FAIL overwrite_wconflict: got %b want 0", wconf_a); end
        idle();
        set_r(0, 9'd10);
        set_r(1, 9'd10);
        step();
        n_vec++; if (dout_a[31:0] !== 32'hAABB_CC11)  begin n_err++; $display("FAIL overwrite_p0: got %h want aabbcc11", dout_a[31:0]); end
        n_vec++; if (dout_a[63:32] !== 32'hAABB_CC11) begin n_err++; $display("FAIL overwrite_p1: got %h want aabbcc11", dout_a[63:32]); end
        idle();
        step();
        n_vec++; if (dout_a[31:0] !== 32'hAABB_CC11)  begin n_err++; $display("FAIL hold_p0: got %h want aabbcc11", dout_a[31:0]); end
        n_vec++; if (rvalid_a !== 2'b00)              begin n_err++; $display("FAIL hold_rvalid: got %b want 00", rvalid_a); end
        $display("test_overwrite: @10 reads aabbcc11 and holds when idle");
    endtask

    task automatic test_collision();
        set_w(0, 9'd7, 4'hF, 32'h1111_1111);
        set_w(1, 9'd7, 4'h3, 32'h2222_2222);
        step();
        n_vec++; if (wconf_a !== 1'b1) begin n_err++; $display("FAIL collide_wconflict_a: got %b want 1", wconf_a); end
        n_vec++; if (wconf_b !== 1'b1) begin n_err++; $display("FAIL collide_wconflict_b: got %b want 1", wconf_b); end
        idle();
        set_r(0, 9'd7);
        set_r(1, 9'd7);
        step();
        n_vec++; if (wconf_a !== 1'b0)                begin n_err++; $display("FAIL collide_wconflict_drop: got %b want 0", wconf_a); end
        n_vec++; if (dout_a[31:0] !== 32'h1111_2222)  begin n_err++; $display("FAIL collide_p0: got %h want 11112222", dout_a[31:0]); end
        n_vec++; if (dout_a[63:32] !== 32'h1111_2222) begin n_err++; $display("FAIL collide_p1: got %h want 11112222", dout_a[63:32]); end
        idle();
        $display("test_collision: @7 merged to 11112222, wconflict one cycle");
    endtask

    task automatic test_merge();
        set_w(0, 9'd20, 4'hC, 32'hAAAA_0000);
        set_w(1, 9'd20, 4'h3, 32'h0000_BBBB);
        step();
        n_vec++; if (wconf_a !== 1'b0) begin n_err++; $display("FAIL merge_wconflict: got %b want 0", wconf_a); end
        idle();
        set_r(0, 9'd20);
        step();
        n_vec++; if (dout_a[31:0] !== 32'hAAAA_BBBB) begin n_err++; $display("FAIL merge_p0: got %h want aaaabbbb", dout_a[31:0]); end
        idle();
        $display("test_merge: disjoint lanes @20 merged to aaaabbbb");
    endtask

    task automatic test_bypass();
        set_w(0, 9'd7, 4'hC, 32'h3333_3333);
        set_r(0, 9'd7);
        set_r(1, 9'd7);
        step();
        n_vec++; if (dout_a[31:0] !== 32'h3333_2222)  begin n_err++; $display("FAIL bypass_on_p0: got %h want 33332222", dout_a[31:0]); end
        n_vec++; if (dout_a[63:32] !== 32'h3333_2222) begin n_err++; $display("FAIL bypass_on_p1: got %h want 33332222", dout_a[63:32]); end
        n_vec++; if (dout_b[31:0] !== 32'h1111_2222)  begin n_err++; $display("FAIL bypass_off_p0: got %h want 11112222", dout_b[31:0]); end
        idle();
        set_r(0, 9'd7);
        step();
        n_vec++; if (dout_a[31:0] !== 32'h3333_2222)  begin n_err++; $display("FAIL bypass_on_next: got %h want 33332222", dout_a[31:0]); end
        n_vec++; if (dout_b[31:0] !== 32'h3333_2222)  begin n_err++; $display("FAIL bypass_off_next: got %h want 33332222", dout_b[31:0]); end
        idle();
        $display("test_bypass: same-edge read @7 new vs old data");
    endtask

    task automatic test_reset_mid();
        set_r(0, 9'd10);
        set_r(1, 9'd10);
        step();
        n_vec++; if (dout_a[31:0] !== 32'hAABB_CC11) begin n_err++; $display("FAIL premid_p0: got %h want aabbcc11", dout_a[31:0]); end
        idle();
        #3 rst_l = 1'b0;
        #1;
        n_vec++; if (dout_a !== '0)      begin n_err++; $display("FAIL midreset_dout: got %h want 0", dout_a); end
        n_vec++; if (rvalid_a !== 2'b00) begin n_err++; $display("FAIL midreset_rvalid: got %b want 00", rvalid_a); end
        #1 rst_l = 1'b1;
        set_r(0, 9'd10);
        set_r(1, 9'd7);
        step();
        n_vec++; if (dout_a[31:0] !== 32'hAABB_CCDD)  begin n_err++; $display("FAIL postreset_p0: got %h want aabbccdd", dout_a[31:0]); end
        n_vec++; if (dout_a[63:32] !== 32'h3333_1111) begin n_err++; $display("FAIL postreset_p1: got %h want 33331111", dout_a[63:32]); end
        n_vec++; if (rvalid_a !== 2'b11)              begin n_err++; $display("FAIL postreset_rvalid: got %b want 11", rvalid_a); end
        idle();
        $display("test_reset_mid: async clear, LVT back to bank 0");
    endtask

    task automatic test_bounds();
        set_w(0, 9'd511, 4'hF, 32'hDEAD_BEEF);
        set_w(1, 9'd0, 4'hF, 32'h0BAD_F00D);
        step();
        n_vec++; if (wconf_a !== 1'b0) begin n_err++; $display("FAIL bounds_wconflict: got %b want 0", wconf_a); end
        idle();
        set_r(0, 9'd511);
        set_r(1, 9'd0);
        step();
        n_vec++; if (dout_a[31:0] !== 32'hDEAD_BEEF)  begin n_err++; $display("FAIL bounds_a_p0: got %h want deadbeef", dout_a[31:0]); end
        n_vec++; if (dout_a[63:32] !== 32'h0BAD_F00D) begin n_err++; $display("FAIL bounds_a_p1: got %h want 0badf00d", dout_a[63:32]); end
        n_vec++; if (dout_c[31:0] !== 32'h0)          begin n_err++; $display("FAIL oor_c_p0: got %h want 00000000", dout_c[31:0]); end
        n_vec++; if (dout_c[63:32] !== 32'h0BAD_F00D) begin n_err++; $display("FAIL oor_c_p1: got %h want 0badf00d", dout_c[63:32]); end
        n_vec++; if (rvalid_c !== 2'b11)              begin n_err++; $display("FAIL oor_c_rvalid: got %b want 11", rvalid_c); end
        idle();
        set_w(0, 9'd511, 4'hF, 32'h1234_5678);
        set_w(1, 9'd511, 4'hF, 32'h8765_4321);
        step();
        n_vec++; if (wconf_a !== 1'b1) begin n_err++; $display("FAIL edge_wconflict_a: got %b want 1", wconf_a); end
        n_vec++; if (wconf_c !== 1'b0) begin n_err++; $display("FAIL oor_wconflict_c: got %b want 0", wconf_c); end
        idle();
        set_r(0, 9'd511);
        step();
        n_vec++; if (dout_a[31:0] !== 32'h8765_4321) begin n_err++; $display("FAIL edge_win_p0: got %h want 87654321", dout_a[31:0]); end
        n_vec++; if (rvalid_b !== 2'b01)             begin n_err++; $display("FAIL edge_rvalid_b: got %b want 01", rvalid_b); end
        idle();
        $display("test_bounds: @511/@0 independent, out-of-range dropped");
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_overwrite();
        test_collision();
        test_merge();
        test_bypass();
        test_reset_mid();
        test_bounds();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_lvt_nrnw.md
Name: ram_lvt_nrnw

Overview:
- Multi-port behavioural RAM with nRPORTS read ports and nWPORTS write ports (up to 4) on one clock.
- Generalises the existing 2-read/1-write replicated RAM wrapper to several write ports.
- Storage: one bank replica per (write port, read port) pair, plus a byte-lane Live Value Table (LVT) that records which write port last wrote each lane of each word.
- Used as a multi-ported register/scratch store in the core.

Parameters:
- NUM_WMASKS, 4, byte lanes per word; DATA_WIDTH must be divisible by NUM_WMASKS.
- MEMD, 512, number of words.
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 9, address width; MEMD <= 2**ADDR_WIDTH.
- nRPORTS, 2, read ports, 1..4.
- nWPORTS, 2, write ports, 1..4.
- IZERO, 0, 1 = all bank replicas initialised to zero at time 0 (simulation init).
- BYPASS, 1, 1 = a read of a word written at the same edge returns the new data; 0 = returns the old data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_l  in  1  asynchronous active-low reset.
- wcsb  in  nWPORTS  active-low write enable per write port.
- wmask  in  nWPORTS*NUM_WMASKS  byte-lane write mask per port, active high.
- waddr  in  nWPORTS*ADDR_WIDTH  write address per port.
- wdin  in  nWPORTS*DATA_WIDTH  write data per port.
- rcsb  in  nRPORTS  active-low read enable per read port.
- raddr  in  nRPORTS*ADDR_WIDTH  read address per port.
- dout  out  nRPORTS*DATA_WIDTH  registered read data.
- rvalid  out  nRPORTS  dout of that port updated on the previous edge.
- wconflict  out  1  registered flag: two enabled write ports hit the same address with overlapping mask lanes.

Behaviour:
- Packing: port p occupies bits [p*W +: W] of every vector; port 0 is least significant.
- Clock and reset: one clock domain (clk); reset is asynchronous and active-low (rst_l).
- While rst_l = 0:
  - dout = 0, rvalid = 0, wconflict = 0.
  - All LVT entries = 0.
  - Writes and reads are ignored.
  - Bank contents are not reset.
- Write, at each edge, per enabled write port w (wcsb[w]=0, waddr < MEMD):
  - Every lane l with wmask[w][l]=1 is written into all nRPORTS replicas of bank w.
  - LVT[addr][l] <= w.
  - LVT lane field width = max(1, clog2(nWPORTS)).
- Same-edge write collision (same address, overlapping lanes):
  - Highest-index port wins per lane in both the LVT and the bypass path.
  - Non-overlapping lanes merge.
  - wconflict = 1 on the following cycle only; it is 0 otherwise.
- Read latency is 1 cycle. Per read port r with rcsb[r]=0, at the edge:
  - Each lane l of dout[r] <= bank[LVT[raddr][l]] replica r, lane l.
  - rvalid[r] <= 1.
- Idle read port (rcsb[r]=1): dout[r] holds its value; rvalid[r] <= 0.
- Bypass, when a read address equals a same-edge write address:
  - BYPASS=1: written lanes return the winning new data; unwritten lanes return stored data.
  - BYPASS=0: every lane returns pre-edge data.
- Out-of-range addresses (>= MEMD):
  - Writes are dropped, with no LVT change.
  - Reads return 0 and still set rvalid.
- Address MEMD-1 and address 0 are independent words; there is no wrap or alias.
- Reset asserted mid-operation:
  - Outputs clear immediately (asynchronously).
  - The cleared LVT points every lane at bank 0, so after reset a read returns bank 0's stored lane data.
  - Data retention across reset is not guaranteed.
- nWPORTS=1: LVT still present (1 bit, always 0); the block behaves as plain nR1W.
- wconflict ignores out-of-range or disabled ports.

Test Plan:
1. IZERO=1, reset released, rcsb=00, raddr port0=5, port1=300 -> next cycle dout=0 on both, rvalid=11; rcsb=11 next cycle -> rvalid=00, dout held.
2. W0 writes 0xAABBCCDD @10 mask 1111; next cycle W1 writes 0x00000011 @10 mask 0001; read @10 on both ports -> 0xAABBCC11, wconflict stays 0.
3. Same edge: W0 0x11111111 mask 1111 @7 and W1 0x22222222 mask 0011 @7 -> read @7 = 0x11112222; wconflict=1 for exactly one cycle.
4. BYPASS=1: @7 holds 0x11112222; same edge read @7 and W0 writes 0x33333333 mask 1100 -> dout 0x33332222. Repeat with BYPASS=0 -> dout 0x11112222, then 0x33332222 on the next read.
5. After test 2, pulse rst_l low mid-cycle -> dout=0, rvalid=0 immediately; after release, read @10 -> 0xAABBCCDD (bank 0 data, LVT cleared).
6. W0 writes 0xDEADBEEF @511, W1 writes 0x0BADF00D @0 same edge; read port0 @511, port1 @0 -> 0xDEADBEEF / 0x0BADF00D, wconflict=0. With MEMD=500, a write @511 is dropped and a read @511 -> 0 with rvalid=1.
